// File: rtl/pipeline_skid_chain.sv
// pipeline_skid_chain
//   Ready/valid pipeline of DEPTH stages, WIDTH bits wide, used to retime long
//   paths between a producer and a consumer. Each stage is one of two kinds:
//     REG_READY=1 : two-entry skid stage (main + skid). Its ready comes straight
//                   from a flop, so no combinational ready path crosses it.
//     REG_READY=0 : single-entry stage. Its ready is ~valid | ready from below.
//   Adds a synchronous flush of all held entries and a registered occupancy count.
//
// Ports
//   clk        : clock, everything on the rising edge
//   rst        : synchronous reset, active-high (clears valids, data and count)
//   flush      : synchronous clear of all stored entries; blocks input that cycle
//   in_valid   : upstream data valid
//   in_ready   : upstream may transfer this cycle
//   in_data    : upstream payload
//   out_valid  : downstream data valid
//   out_ready  : downstream accepts this cycle
//   out_data   : downstream payload
//   occupancy  : number of entries currently held (0..CAP)
module pipeline_skid_chain #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int REG_READY = 1,
    localparam int CAP      = DEPTH * ((REG_READY != 0) ? 2 : 1),
    localparam int OCC_W    = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    // Per-stage handshake: stage k consumes stg_vld_in/stg_dat_in and
    // presents stg_vld_out/stg_dat_out, seeing stg_rdy_dn from below.
    logic [DEPTH-1:0] stg_vld_in;
    logic [DEPTH-1:0] stg_rdy;
    logic [DEPTH-1:0] stg_vld_out;
    logic [DEPTH-1:0] stg_rdy_dn;
    logic [WIDTH-1:0] stg_dat_in  [DEPTH];
    logic [WIDTH-1:0] stg_dat_out [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Nothing may enter while a flush is in progress.
            assign stg_vld_in[k] = in_valid & ~flush;
            assign stg_dat_in[k] = in_data;
        end else begin : g_link
            assign stg_vld_in[k] = stg_vld_out[k-1];
            assign stg_dat_in[k] = stg_dat_out[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail
            assign stg_rdy_dn[k] = out_ready;
        end else begin : g_mid
            assign stg_rdy_dn[k] = stg_rdy[k+1];
        end

        if (REG_READY != 0) begin : g_skid
            logic             m_vld_q, m_vld_d, s_vld_q, s_vld_d;
            logic [WIDTH-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
            logic             acc, drn;

            assign acc = stg_vld_in[k] & ~s_vld_q;
            assign drn = m_vld_q & stg_rdy_dn[k];

            always_comb begin
                m_vld_d = m_vld_q;
                m_dat_d = m_dat_q;
                s_vld_d = s_vld_q;
                s_dat_d = s_dat_q;
                if (m_vld_q && !drn) begin
                    // Main is stuck: a new item can only go into the skid slot.
                    if (acc) begin
                        s_vld_d = 1'b1;
                        s_dat_d = stg_dat_in[k];
                    end
                end else if (s_vld_q) begin
                    // Main frees up: promote the skid entry. Ready is low, so
                    // no accept competes with this move.
                    m_vld_d = 1'b1;
                    m_dat_d = s_dat_q;
                    s_vld_d = 1'b0;
                end else if (acc) begin
                    m_vld_d = 1'b1;
                    m_dat_d = stg_dat_in[k];
                end else begin
                    m_vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    m_vld_q <= 1'b0;
                    s_vld_q <= 1'b0;
                    m_dat_q <= '0;
                    s_dat_q <= '0;
                end else if (flush) begin
                    m_vld_q <= 1'b0;
                    s_vld_q <= 1'b0;
                end else begin
                    m_vld_q <= m_vld_d;
                    s_vld_q <= s_vld_d;
                    m_dat_q <= m_dat_d;
                    s_dat_q <= s_dat_d;
                end
            end

            assign stg_rdy[k]     = ~s_vld_q;
            assign stg_vld_out[k] = m_vld_q;
            assign stg_dat_out[k] = m_dat_q;
        end else begin : g_reg
            logic             m_vld_q, m_vld_d;
            logic [WIDTH-1:0] m_dat_q, m_dat_d;
            logic             rdy, acc, drn;

            // Ready passes through combinationally when the slot will drain.
            assign rdy = ~m_vld_q | stg_rdy_dn[k];
            assign acc = stg_vld_in[k] & rdy;
            assign drn = m_vld_q & stg_rdy_dn[k];

            always_comb begin
                m_vld_d = acc | (m_vld_q & ~drn);
                m_dat_d = acc ? stg_dat_in[k] : m_dat_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    m_vld_q <= 1'b0;
                    m_dat_q <= '0;
                end else if (flush) begin
                    m_vld_q <= 1'b0;
                end else begin
                    m_vld_q <= m_vld_d;
                    m_dat_q <= m_dat_d;
                end
            end

            assign stg_rdy[k]     = rdy;
            assign stg_vld_out[k] = m_vld_q;
            assign stg_dat_out[k] = m_dat_q;
        end
    end

    assign in_ready  = stg_rdy[0] & ~flush;
    assign out_valid = stg_vld_out[DEPTH-1];
    assign out_data  = stg_dat_out[DEPTH-1];

    // Occupancy follows the outer handshakes only; internal moves do not change it.
    logic             acc_in, drn_out;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign acc_in  = in_valid & in_ready;
    assign drn_out = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q + OCC_W'(acc_in) - OCC_W'(drn_out);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_skid_chain.sv
module tb_pipeline_skid_chain;

    logic        clk;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    // DUT 0: DEPTH=2 skid (CAP 4); DUT 1: DEPTH=3 skid (CAP 6); DUT 2: DEPTH=2 single-entry (CAP 2)
    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [31:0] od_a, od_b, od_c;
    logic [2:0]  oc_a, oc_b;
    logic [1:0]  oc_c;

    pipeline_skid_chain #(.WIDTH(32), .DEPTH(2), .REG_READY(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .occupancy(oc_a));
    pipeline_skid_chain #(.WIDTH(32), .DEPTH(3), .REG_READY(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .occupancy(oc_b));
    pipeline_skid_chain #(.WIDTH(32), .DEPTH(2), .REG_READY(0)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
        .occupancy(oc_c));

    logic        ivr [3];
    logic        ov  [3];
    logic [31:0] od  [3];
    int          occ [3];
    assign ivr[0] = ir_a;  assign ivr[1] = ir_b;  assign ivr[2] = ir_c;
    assign ov[0]  = ov_a;  assign ov[1]  = ov_b;  assign ov[2]  = ov_c;
    assign od[0]  = od_a;  assign od[1]  = od_b;  assign od[2]  = od_c;
    assign occ[0] = 32'(oc_a); assign occ[1] = 32'(oc_b); assign occ[2] = 32'(oc_c);

    int cap [3] = '{4, 6, 2};

    // Reference model: one FIFO per DUT holding everything accepted but not yet delivered.
    logic [31:0] mq [3][4096];
    int          hd [3];
    int          tl [3];
    int          total  = 0;
    int          passed = 0;

    function automatic int cnt(int d);
        return tl[d] - hd[d];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and update the model from the handshakes seen this cycle.
    task automatic tick();
        logic a [3];
        logic r [3];
        logic ne;
        for (int d = 0; d < 3; d++) begin
            a[d] = in_valid & ivr[d];
            r[d] = ov[d] & out_ready;
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                hd[d] = 0;
                tl[d] = 0;
            end else if (flush) begin
                hd[d] = tl[d];
            end else begin
                ne = (tl[d] > hd[d]);
                if (a[d]) begin
                    mq[d][tl[d] % 4096] = in_data;
                    tl[d]++;
                end
                if (r[d] && ne) hd[d]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ov[d] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %0b want 0", d, ov[d]);
            else passed++;
            total++;
            if (od[d] !== 32'h0) $display("FAIL reset_out_data[%0d]: got %0h want 0", d, od[d]);
            else passed++;
            total++;
            if (occ[d] !== 0) $display("FAIL reset_occupancy[%0d]: got %0d want 0", d, occ[d]);
            else passed++;
            total++;
            if (ivr[d] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %0b want 1", d, ivr[d]);
            else passed++;
        end
        tick();
    endtask

    task automatic test_stream();
        int pushed = 0, rcv = 0, first_acc = -1, first_ov = -1, bubbles = 0;
        logic took;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && rcv < 16; c++) begin
            in_valid = (pushed < 16);
            in_data  = 32'(pushed + 1);
            @(negedge clk);
            took = in_valid & ivr[1];
            if (took && first_acc < 0) first_acc = c;
            if (ov[1] && first_ov < 0) first_ov = c;
            if (first_ov >= 0 && !ov[1]) bubbles++;
            if (ov[1]) begin
                total++;
                if (od[1] !== 32'(rcv + 1)) $display("FAIL stream_data: got %0h want %0h", od[1], rcv + 1);
                else passed++;
                rcv++;
            end
            tick();
            if (took) pushed++;
        end
        in_valid = 1'b0;
        total++;
        if (first_ov - first_acc !== 3) $display("FAIL stream_latency: got %0d want 3", first_ov - first_acc);
        else passed++;
        total++;
        if (rcv !== 16) $display("FAIL stream_count: got %0d want 16", rcv);
        else passed++;
        total++;
        if (bubbles !== 0) $display("FAIL stream_bubbles: got %0d want 0", bubbles);
        else passed++;
    endtask

    task automatic test_backpressure();
        int pushed = 0, rcv = 0;
        logic took;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(pushed);
            @(negedge clk);
            total++;
            if (ivr[0] !== (occ[0] != 4)) $display("FAIL full_ready_a: got %0b at occupancy %0d", ivr[0], occ[0]);
            else passed++;
            total++;
            if (ivr[1] !== (occ[1] != 6)) $display("FAIL full_ready_b: got %0b at occupancy %0d", ivr[1], occ[1]);
            else passed++;
            took = ivr[0];
            tick();
            if (took) pushed++;
        end
        @(negedge clk);
        total++;
        if (pushed !== 4) $display("FAIL bp_accepted: got %0d want 4", pushed);
        else passed++;
        total++;
        if (ivr[0] !== 1'b0) $display("FAIL bp_in_ready: got %0b want 0", ivr[0]);
        else passed++;
        total++;
        if (occ[0] !== 4) $display("FAIL bp_occupancy: got %0d want 4", occ[0]);
        else passed++;
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            in_valid = (pushed < 6);
            in_data  = 32'hA0 + 32'(pushed);
            @(negedge clk);
            if (ov[0]) begin
                total++;
                if (od[0] !== 32'hA0 + 32'(rcv)) $display("FAIL bp_data: got %0h want %0h", od[0], 32'hA0 + rcv);
                else passed++;
                rcv++;
            end
            took = in_valid & ivr[0];
            tick();
            if (took) pushed++;
        end
        in_valid = 1'b0;
        total++;
        if (rcv !== 6) $display("FAIL bp_delivered: got %0d want 6", rcv);
        else passed++;
    endtask

    task automatic test_random();
        int   got [3] = '{0, 0, 0};
        logic stall [3] = '{1'b0, 1'b0, 1'b0};
        logic [31:0] held [3];
        do_reset();
        for (int c = 0; c < 20000 && (got[0] < 1000 || got[1] < 1000 || got[2] < 1000); c++) begin
            in_valid  = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
            in_data   = $urandom;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (occ[d] !== cnt(d) || occ[d] > cap[d])
                    $display("FAIL rand_occupancy[%0d]: got %0d want %0d", d, occ[d], cnt(d));
                else passed++;
                if (stall[d]) begin
                    total++;
                    if (ov[d] !== 1'b1 || od[d] !== held[d])
                        $display("FAIL rand_hold[%0d]: got v=%0b %0h want v=1 %0h", d, ov[d], od[d], held[d]);
                    else passed++;
                end
                if (ov[d] && out_ready) begin
                    total++;
                    if (cnt(d) < 1 || od[d] !== mq[d][hd[d] % 4096])
                        $display("FAIL rand_data[%0d]: got %0h want %0h (model holds %0d)", d, od[d], mq[d][hd[d] % 4096], cnt(d));
                    else passed++;
                    got[d]++;
                end
                stall[d] = ov[d] & ~out_ready;
                held[d]  = od[d];
            end
            tick();
        end
        in_valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (got[d] < 1000) $display("FAIL rand_count[%0d]: got %0d want >= 1000", d, got[d]);
            else passed++;
        end
    endtask

    task automatic test_flush();
        int pushed = 0, rcv = 0;
        logic took;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hF0 + 32'(c);
            @(negedge clk);
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hEE;
        @(negedge clk);
        total++;
        if (occ[0] !== 3) $display("FAIL flush_held: got %0d want 3", occ[0]);
        else passed++;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ivr[d] !== 1'b0) $display("FAIL flush_in_ready[%0d]: got %0b want 0", d, ivr[d]);
            else passed++;
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (occ[d] !== 0 || ov[d] !== 1'b0)
                $display("FAIL flush_cleared[%0d]: got occ=%0d v=%0b want 0 0", d, occ[d], ov[d]);
            else passed++;
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 30 && rcv < 4; c++) begin
            in_valid = (pushed < 4);
            in_data  = 32'hB0 + 32'(pushed);
            @(negedge clk);
            if (ov[0]) begin
                total++;
                if (od[0] !== 32'hB0 + 32'(rcv)) $display("FAIL flush_after_data: got %0h want %0h", od[0], 32'hB0 + rcv);
                else passed++;
                rcv++;
            end
            took = in_valid & ivr[0];
            tick();
            if (took) pushed++;
        end
        in_valid = 1'b0;
        total++;
        if (rcv !== 4) $display("FAIL flush_after_count: got %0d want 4", rcv);
        else passed++;
    endtask

    task automatic test_simul();
        int rcv = 1;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(c);
            @(negedge clk);
            tick();
        end
        in_valid = 1'b1; in_data = 32'hC3; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (occ[0] !== 3 || ivr[0] !== 1'b1) $display("FAIL simul_before: got occ=%0d rdy=%0b want 3 1", occ[0], ivr[0]);
        else passed++;
        total++;
        if (ov[0] !== 1'b1 || od[0] !== 32'hC0) $display("FAIL simul_head: got v=%0b %0h want 1 c0", ov[0], od[0]);
        else passed++;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (occ[0] !== 3) $display("FAIL simul_occ_after: got %0d want 3", occ[0]);
        else passed++;
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && rcv < 4; c++) begin
            @(negedge clk);
            if (ov[0]) begin
                total++;
                if (od[0] !== 32'hC0 + 32'(rcv)) $display("FAIL simul_order: got %0h want %0h", od[0], 32'hC0 + rcv);
                else passed++;
                rcv++;
            end
            tick();
        end
        total++;
        if (rcv !== 4) $display("FAIL simul_count: got %0d want 4", rcv);
        else passed++;
    endtask

    task automatic test_rst_mid();
        int emitted = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hD0 + 32'(c);
            @(negedge clk);
            tick();
        end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (occ[d] !== 0) $display("FAIL rst_mid_occupancy[%0d]: got %0d want 0", d, occ[d]);
            else passed++;
        end
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (ov[d]) emitted++;
            tick();
        end
        total++;
        if (emitted !== 0) $display("FAIL rst_mid_emitted: got %0d want 0", emitted);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            hd[d] = 0;
            tl[d] = 0;
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_simul();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
